// File: rtl/clap_pkg.sv
// Shared types, defaults and sizing helper for the double-clap detector.
package clap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HIGH1,
    GAP,
    HIGH2,
    COOLDOWN
  } clap_state_e;

  localparam int unsigned DEF_ENERGY_WIDTH    = 32;
  localparam int unsigned DEF_ON_THRESHOLD    = 1000;
  localparam int unsigned DEF_OFF_THRESHOLD   = 500;
  localparam int unsigned DEF_MAX_CLAP_FRAMES = 4;
  localparam int unsigned DEF_MIN_GAP_FRAMES  = 3;
  localparam int unsigned DEF_MAX_GAP_FRAMES  = 20;
  localparam int unsigned DEF_COOLDOWN_FRAMES = 8;

  // Counter must hold the largest of the frame limits, plus one spare bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/energy_hysteresis.sv
// Combinational loud/quiet classifier for one energy frame.
module energy_hysteresis #(
  parameter int unsigned ENERGY_WIDTH = 32
) (
  input  logic [ENERGY_WIDTH-1:0] energy_data,
  input  logic [ENERGY_WIDTH-1:0] on_threshold,
  input  logic [ENERGY_WIDTH-1:0] off_threshold,
  output logic                    hi,
  output logic                    lo
);

  // Frames between the thresholds report neither; the FSM keeps its sense.
  assign hi = (energy_data >= on_threshold);
  assign lo = (energy_data <  off_threshold);

endmodule

// File: rtl/clap_detector.sv
// Recognises two short loud bursts separated by a bounded quiet gap and
// toggles the light on each such double clap.
module clap_detector
  import clap_pkg::*;
#(
  parameter int unsigned ENERGY_WIDTH    = DEF_ENERGY_WIDTH,
  parameter int unsigned ON_THRESHOLD    = DEF_ON_THRESHOLD,
  parameter int unsigned OFF_THRESHOLD   = DEF_OFF_THRESHOLD,
  parameter int unsigned MAX_CLAP_FRAMES = DEF_MAX_CLAP_FRAMES,
  parameter int unsigned MIN_GAP_FRAMES  = DEF_MIN_GAP_FRAMES,
  parameter int unsigned MAX_GAP_FRAMES  = DEF_MAX_GAP_FRAMES,
  parameter int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter logic        LIGHT_INIT      = 1'b0
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [ENERGY_WIDTH-1:0] energy_data,
  input  logic                    energy_valid,
  output logic                    energy_ready,
  output logic                    light,
  output logic                    clap_pulse
);

  localparam int unsigned CW = cnt_width(MAX_CLAP_FRAMES, MAX_GAP_FRAMES, COOLDOWN_FRAMES);

  localparam logic [ENERGY_WIDTH-1:0] ON_TH  = ENERGY_WIDTH'(ON_THRESHOLD);
  localparam logic [ENERGY_WIDTH-1:0] OFF_TH = ENERGY_WIDTH'(OFF_THRESHOLD);
  localparam logic [CW-1:0] MAX_CLAP = CW'(MAX_CLAP_FRAMES);
  localparam logic [CW-1:0] MIN_GAP  = CW'(MIN_GAP_FRAMES);
  localparam logic [CW-1:0] MAX_GAP  = CW'(MAX_GAP_FRAMES);
  localparam logic [CW-1:0] COOLDOWN_LEN = CW'(COOLDOWN_FRAMES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  clap_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          ready_q, ready_d;
  logic          light_q, light_d;
  logic          pulse_q, pulse_d;
  logic          hi, lo, accept;

  energy_hysteresis #(
    .ENERGY_WIDTH (ENERGY_WIDTH)
  ) u_hyst (
    .energy_data   (energy_data),
    .on_threshold  (ON_TH),
    .off_threshold (OFF_TH),
    .hi            (hi),
    .lo            (lo)
  );

  assign accept  = energy_valid && ready_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign ready_d = 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    light_d = light_q;
    pulse_d = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (hi) begin
            state_d = HIGH1;
            cnt_d   = CNT_ONE;
          end
        end
        HIGH1: begin
          if (lo) begin
            state_d = GAP;
            cnt_d   = CNT_ONE;
          end else if (cnt_q == MAX_CLAP) begin
            state_d = COOLDOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        GAP: begin
          // A burst arriving too early restarts the sequence as a new clap 1.
          if (hi) begin
            state_d = (cnt_q >= MIN_GAP) ? HIGH2 : HIGH1;
            cnt_d   = CNT_ONE;
          end else if (cnt_q == MAX_GAP) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HIGH2: begin
          if (lo) begin
            light_d = ~light_q;
            pulse_d = 1'b1;
            state_d = COOLDOWN;
            cnt_d   = '0;
          end else if (cnt_q == MAX_CLAP) begin
            state_d = COOLDOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        COOLDOWN: begin
          if (!lo) begin
            cnt_d = '0;
          end else if (cnt_inc == COOLDOWN_LEN) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      light_q <= LIGHT_INIT;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      light_q <= light_d;
      pulse_q <= pulse_d;
    end
  end

  assign energy_ready = ready_q;
  assign light        = light_q;
  assign clap_pulse   = pulse_q;

endmodule

// File: tb/tb_clap_detector.sv
// Scoreboard bench for clap_detector: each frame pushes its expected
// pulse/light pair, popped and compared one cycle after acceptance.
module tb_clap_detector;
  import clap_pkg::*;

  typedef struct packed {
    logic pulse;
    logic light;
  } exp_t;

  logic        clock;
  logic        resetn;
  logic [31:0] energy_data;
  logic        energy_valid;
  logic        energy_ready;
  logic        light;
  logic        clap_pulse;

  int   n_checks;
  int   n_errors;
  int   n_frames;
  logic exp_light;
  exp_t sb_q[$];

  clap_detector dut (
    .clock        (clock),
    .resetn       (resetn),
    .energy_data  (energy_data),
    .energy_valid (energy_valid),
    .energy_ready (energy_ready),
    .light        (light),
    .clap_pulse   (clap_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] e, input logic exp_pulse);
    exp_t x;
    @(negedge clock);
    energy_data  = e;
    energy_valid = 1'b1;
    if (exp_pulse) exp_light = ~exp_light;
    x.pulse = exp_pulse;
    x.light = exp_light;
    sb_q.push_back(x);
    @(posedge clock);
    #1;
    energy_valid = 1'b0;
    x = sb_q.pop_front();
    n_frames++;
    $display("frame %0d data=%0d pulse=%0b light=%0b", n_frames, e, clap_pulse, light);
    check("clap_pulse", 32'(clap_pulse), 32'(x.pulse));
    check("light", 32'(light), 32'(x.light));
    check("energy_ready", 32'(energy_ready), 32'd1);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) send(32'd0, 1'b0);
  endtask

  // Cycles with valid low and random data must change nothing.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      energy_data  = $urandom;
      energy_valid = 1'b0;
      @(posedge clock);
      #1;
      $display("idle cycle data=%0h pulse=%0b light=%0b", energy_data, clap_pulse, light);
      check("idle_pulse", 32'(clap_pulse), 32'd0);
      check("idle_light", 32'(light), 32'(exp_light));
    end
  endtask

  task automatic short_double_clap();
    send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b1);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    n_frames     = 0;
    exp_light    = 1'b0;
    resetn       = 1'b0;
    energy_valid = 1'b1;
    energy_data  = 32'd2000;

    // Reset held with valid high
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 32'(energy_ready), 32'd0);
    check("rst_light", 32'(light), 32'd0);
    check("rst_pulse", 32'(clap_pulse), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    check("ready_before_edge", 32'(energy_ready), 32'd0);
    @(posedge clock);
    #1;
    energy_valid = 1'b0;
    check("ready_after_edge", 32'(energy_ready), 32'd1);
    check("state_after_release", 32'(dut.state_q), 32'(IDLE));

    // Double clap, then again after cooldown
    send(32'd0, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b1);
    quiet(8);
    send(32'd0, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b1);
    quiet(8);

    // Single clap times out after the maximum gap
    send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    quiet(20);
    check("single_clap_idle", 32'(dut.state_q), 32'(IDLE));
    short_double_clap();
    quiet(8);

    // Long burst: cooldown needs 8 consecutive quiet frames
    for (int i = 0; i < 5; i++) send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    quiet(6);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    quiet(8);
    short_double_clap();
    quiet(8);

    // Mid-band frames keep a burst high
    send(32'd2000, 1'b0);
    send(32'd700, 1'b0);
    send(32'd700, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b1);
    quiet(8);

    // Invalid cycles inside the gap are not counted
    send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    idle(4);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b1);
    quiet(8);

    // Early second burst becomes clap 1
    send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b1);
    quiet(8);

    // Reset in the middle of a gap
    send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    exp_light = 1'b0;
    check("midrst_light", 32'(light), 32'd0);
    check("midrst_pulse", 32'(clap_pulse), 32'd0);
    check("midrst_ready", 32'(energy_ready), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    send(32'd2000, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd0, 1'b0);
    send(32'd2000, 1'b0);
    send(32'd0, 1'b1);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clap_detector.md
# clap_detector

Consumes the energy stream produced by the energy computation stage. It classifies each energy frame against a hysteresis threshold and recognises a "double clap": two short loud bursts separated by a bounded quiet gap. On each recognised double clap it toggles the light output. It sits between the energy stage and the board LED/relay driver.

## Interface
- ENERGY_WIDTH, 32, width of energy_data; compared unsigned.
- ON_THRESHOLD, 1000, energy at or above this starts a burst.
- OFF_THRESHOLD, 500, energy below this ends a burst; must be ≤ ON_THRESHOLD.
- MAX_CLAP_FRAMES, 4, max frames a burst may stay high and still count as a clap; ≥1.
- MIN_GAP_FRAMES, 3, minimum quiet frames between clap 1 and clap 2; ≥1.
- MAX_GAP_FRAMES, 20, quiet frames after clap 1 before the sequence is abandoned; > MIN_GAP_FRAMES.
- COOLDOWN_FRAMES, 8, consecutive quiet frames required before re-arming; ≥1.
- LIGHT_INIT, 0, light value at reset.
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- energy_data  in  ENERGY_WIDTH  energy frame.
- energy_valid  in  1  energy_data valid.
- energy_ready  out  1  frame accepted when valid&&ready.
- light  out  1  light control level.
- clap_pulse  out  1  one-cycle strobe per recognised double clap.

## Operation
- A frame is accepted on an edge where energy_valid && energy_ready. All state and counter updates happen only on accepted frames.
- hi = energy ≥ ON_THRESHOLD. lo = energy < OFF_THRESHOLD. Values between the two thresholds keep the current high/low sense of the state.
- The frame counter `cnt` counts accepted frames. Its width is clog2(max frame parameter)+1, and it saturates at the maximum.
- States:
  - IDLE: hi → HIGH1, cnt=1; otherwise stay.
  - HIGH1:
    - lo → GAP, cnt=1.
    - not lo and cnt==MAX_CLAP_FRAMES → COOLDOWN, cnt=0 (too long to be a clap).
    - else cnt+1.
  - GAP:
    - hi and cnt ≥ MIN_GAP_FRAMES → HIGH2, cnt=1.
    - hi and cnt < MIN_GAP_FRAMES → HIGH1, cnt=1 (the new burst becomes clap 1).
    - not hi and cnt==MAX_GAP_FRAMES → IDLE.
    - else cnt+1.
  - HIGH2:
    - lo → toggle light, assert clap_pulse, → COOLDOWN, cnt=0.
    - not lo and cnt==MAX_CLAP_FRAMES → COOLDOWN, cnt=0, no toggle.
    - else cnt+1.
  - COOLDOWN:
    - lo → cnt+1; when cnt+1==COOLDOWN_FRAMES → IDLE.
    - not lo → cnt=0.
- energy_ready is 1 in every state; the block never backpressures.

## Timing
- Reset values: energy_ready=0, light=LIGHT_INIT, clap_pulse=0, state=IDLE, cnt=0.
- energy_ready rises on the first clock edge after resetn deasserts, and stays 1.
- Latency: light toggles and clap_pulse rises on the same edge that accepts the terminating lo frame of clap 2 (registered; visible the following cycle). clap_pulse is high for exactly one cycle.
- energy_valid held high over consecutive cycles means one frame per cycle. Every state rule holds at full rate.
- resetn asserted mid-sequence returns all outputs and state to their reset values immediately. light reverts to LIGHT_INIT.
- X on energy_data while energy_valid=0 must not affect state.

## Structure
- Package clap_pkg holds:
  - the state enumeration (IDLE, HIGH1, GAP, HIGH2, COOLDOWN);
  - the counter-width function;
  - the default threshold and frame constants.
- One sub-module, energy_hysteresis, is natural: a combinational hi/lo classifier taking energy_data and the two thresholds.
- The FSM and counter remain in clap_detector.

## Test plan
All scenarios use the default parameters.
- **Reset:** hold resetn=0 with energy_valid=1 → energy_ready=0, light=0, clap_pulse=0. Release → energy_ready=1 after one edge.
- **Double clap:** frames 0, 2000, 2000, 0, 0, 0, 2000, 0 → one clap_pulse coincident with the final frame's acceptance; light=1. Repeat after 8 quiet frames → light=0.
- **Single clap:** 2000, 0, then 20 frames of 0 → no pulse, state IDLE. A later valid double clap still toggles.
- **Long burst:** five frames of 2000, then 0 → no pulse; the block needs 8 quiet frames before a new clap registers.
- **Hysteresis and early gap:**
  - 2000, 700, 700, 0 → counts as a 3-frame clap.
  - 2000, 0, 2000 (gap of 1) → second burst treated as clap 1; no toggle.
- **Reset mid-GAP:** after 2000, 0, assert resetn → state IDLE. A following 2000, 0 does not toggle.
